matrix_ctrl_gen: RTL and testbench
==================================

Name: matrix_ctrl_gen

Overview:
Parametrised controller for the heavyhash matrix multiplier, sitting between the M fifo, hashin fifo, column RAMs/PE array and hashout fifo. It keeps internal loop counters (row, column, hash word, drain, output word) instead of relying on external counter flags. The loaded matrix stays resident across hash jobs, and a new matrix is loaded on request. PE pipeline latency and output width are configurable.

Parameters:
COLS, 64, number of column RAMs / PEs (en_column width)
ROWS, 64, words loaded per column
HASH_WORDS, 64, hashin words consumed per job
OUT_WORDS, 4, hashout words written per job
PE_LAT, 3, cycles from the last PE_en word cycle to a valid PE result
Derived localparams: RW=$clog2(ROWS), HW=$clog2(HASH_WORDS), OW=$clog2(OUT_WORDS), each minimum 1.

Ports:
clk  in  1  global clock
rst_n  in  1  asynchronous active-low reset
m_empty  in  1  M fifo empty (first-word-fall-through)
hashin_empty  in  1  hashin fifo empty (first-word-fall-through)
fifo_full  in  1  hashout fifo full
matrix_reload  in  1  one-cycle pulse: load a new matrix
m_re  out  1  M fifo read enable
m_ram_we  out  1  column RAM write enable
m_row  out  RW  column RAM write address
en_column  out  COLS  column RAM / PE select
addr_sel  out  1  RAM address mux: 0=m_row, 1=hash_idx
hash_idx  out  HW  current hash word index
hashin_re  out  1  hashin fifo read enable
PE_en  out  1  PE enable
PE_clr  out  1  PE accumulator clear
out_idx  out  OW  result word select
hashout_we  out  1  hashout fifo write enable
matrix_valid  out  1  resident matrix is complete
busy  out  1  state != IDLE
job_count  out  32  completed jobs, wraps at 2^32

Behaviour:
- rst_n low: immediate async clear to IDLE. All counters are 0. matrix_valid=0, the reload request is 0, job_count=0, addr_sel=0. Every output is 0. Reset mid-load discards the partial matrix.
- Combinational outputs (from state and fifo flags): m_re, m_ram_we, en_column, hashin_re, PE_en, PE_clr, hashout_we, busy. All other outputs are registered.
- reload_req: set by a matrix_reload pulse in any state except LOAD. Cleared on entering LOAD. Pulses during LOAD are dropped.
- States: IDLE, LOAD, MULT, DRAIN, OUT.
- IDLE, priority order:
  - If (reload_req or !matrix_valid) and !m_empty: go to LOAD, clear matrix_valid, set addr_sel=0.
  - Else if matrix_valid and !hashin_empty: PE_clr=1 this cycle, go to MULT, set addr_sel=1.
  - Otherwise stay in IDLE.
- LOAD:
  - m_re = m_ram_we = !m_empty.
  - en_column is one-hot at column counter k while m_re, else 0. m_row = row counter i.
  - Each accepted word increments i. When i==ROWS-1 it wraps to 0 and k increments.
  - Accepting the word at i==ROWS-1, k==COLS-1: set matrix_valid, return to IDLE.
  - Empty fifo stalls; counters hold.
- MULT:
  - hashin_re = PE_en = !hashin_empty. en_column is all ones while hashin_re.
  - hash_idx increments per accepted word.
  - Accepting the word at hash_idx==HASH_WORDS-1: wrap hash_idx to 0, go to DRAIN.
  - Empty fifo stalls with PE_en=0.
- DRAIN: PE_en=1 for exactly PE_LAT cycles (drain counter), then go to OUT.
- OUT:
  - hashout_we = !fifo_full. out_idx increments per write.
  - Write at out_idx==OUT_WORDS-1: wrap out_idx, job_count++, go to IDLE.
  - fifo_full stalls; out_idx holds.
- Fifo read enables are never asserted while the matching empty flag is high. hashout_we is never asserted while fifo_full is high.
- Minimum job length with no stalls: 1 (IDLE) + HASH_WORDS + PE_LAT + OUT_WORDS cycles.
- A reload request during MULT/DRAIN/OUT does not disturb the current job. It is honoured at the next IDLE, before any pending hash.

Test Plan:
- Reset: rst_n low mid-cycle -> all outputs 0 immediately; state IDLE, matrix_valid=0, job_count=0.
- Load (COLS=4, ROWS=4), M fifo non-empty with a 2-cycle empty gap -> 16 m_re pulses. en_column goes 0001 for m_row 0..3, then 0010, ... Held during the gap. matrix_valid=1 the cycle after the 16th write.
- Job (HASH_WORDS=4, PE_LAT=3, OUT_WORDS=2), no stalls -> PE_clr 1 cycle, hashin_re 4 cycles, PE_en 7 cycles, hashout_we 2 cycles with out_idx 0,1. Job takes 10 cycles; job_count=1.
- fifo_full high 5 cycles during OUT -> hashout_we=0 and out_idx held for those cycles; exactly 2 writes total.
- matrix_reload pulsed during MULT, both fifos non-empty -> current job completes, then IDLE enters LOAD (not MULT), matrix_valid=0 until 16 words loaded.
- rst_n asserted at load word 9 -> matrix_valid=0. After release, with hashin non-empty and M empty, no MULT is entered.

Source files
------------

// File: rtl/matrix_ctrl_gen_if.sv
// Bus bundle between the heavyhash matrix controller and its FIFOs, column RAMs and PE array.
// Handshake: FIFOs are first-word-fall-through; a word moves on every cycle its re/we is high, and re/we is only raised while the matching empty/full flag is low.
interface matrix_ctrl_gen_if #(
    parameter int COLS       = 64,
    parameter int ROWS       = 64,
    parameter int HASH_WORDS = 64,
    parameter int OUT_WORDS  = 4
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int HW = (HASH_WORDS > 1) ? $clog2(HASH_WORDS) : 1;
    localparam int OW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

    logic            m_empty;
    logic            hashin_empty;
    logic            fifo_full;
    logic            matrix_reload;

    logic            m_re;
    logic            m_ram_we;
    logic [RW-1:0]   m_row;
    logic [COLS-1:0] en_column;
    logic            addr_sel;
    logic [HW-1:0]   hash_idx;
    logic            hashin_re;
    logic            PE_en;
    logic            PE_clr;
    logic [OW-1:0]   out_idx;
    logic            hashout_we;
    logic            matrix_valid;
    logic            busy;
    logic [31:0]     job_count;
    logic [2:0]      state_dbg;

    modport master (
        input  m_empty, hashin_empty, fifo_full, matrix_reload,
        output m_re, m_ram_we, m_row, en_column, addr_sel, hash_idx,
               hashin_re, PE_en, PE_clr, out_idx, hashout_we,
               matrix_valid, busy, job_count, state_dbg
    );

    modport slave (
        output m_empty, hashin_empty, fifo_full, matrix_reload,
        input  m_re, m_ram_we, m_row, en_column, addr_sel, hash_idx,
               hashin_re, PE_en, PE_clr, out_idx, hashout_we,
               matrix_valid, busy, job_count, state_dbg
    );
endinterface

// File: rtl/matrix_ctrl_gen.sv
// Heavyhash matrix multiplier controller: loads a resident matrix into the column RAMs,
// then runs hash jobs (stream hashin words, drain the PE pipeline, write result words).
module matrix_ctrl_gen #(
    parameter int COLS       = 64,
    parameter int ROWS       = 64,
    parameter int HASH_WORDS = 64,
    parameter int OUT_WORDS  = 4,
    parameter int PE_LAT     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    matrix_ctrl_gen_if.master bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int HW = (HASH_WORDS > 1) ? $clog2(HASH_WORDS) : 1;
    localparam int OW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [HW-1:0] HASH_LAST  = HW'(HASH_WORDS - 1);
    localparam logic [OW-1:0] OUT_LAST   = OW'(OUT_WORDS - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MULT  = 3'd2,
        S_DRAIN = 3'd3,
        S_OUT   = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [HW-1:0] hash_q, hash_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [OW-1:0] out_q, out_d;
    logic          valid_q, valid_d;
    logic          reload_q, reload_d;
    logic          addr_sel_q, addr_sel_d;
    logic [31:0]   jobs_q, jobs_d;

    logic            m_re;
    logic            hashin_re;
    logic            pe_en;
    logic            pe_clr;
    logic            hashout_we;
    logic [COLS-1:0] en_column;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            hash_q     <= '0;
            drain_q    <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            reload_q   <= 1'b0;
            addr_sel_q <= 1'b0;
            jobs_q     <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            hash_q     <= hash_d;
            drain_q    <= drain_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            reload_q   <= reload_d;
            addr_sel_q <= addr_sel_d;
            jobs_q     <= jobs_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        hash_d     = hash_q;
        drain_d    = drain_q;
        out_d      = out_q;
        valid_d    = valid_q;
        reload_d   = reload_q;
        addr_sel_d = addr_sel_q;
        jobs_d     = jobs_q;
        m_re       = 1'b0;
        hashin_re  = 1'b0;
        pe_en      = 1'b0;
        pe_clr     = 1'b0;
        hashout_we = 1'b0;
        en_column  = '0;

        // A reload request is latched outside LOAD and waits for the next IDLE.
        if (bus.matrix_reload && (state_q != S_LOAD)) begin
            reload_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if ((reload_q || !valid_q) && !bus.m_empty) begin
                    state_d    = S_LOAD;
                    valid_d    = 1'b0;
                    reload_d   = 1'b0;
                    addr_sel_d = 1'b0;
                    row_d      = '0;
                    col_d      = '0;
                end else if (valid_q && !bus.hashin_empty) begin
                    pe_clr     = 1'b1;
                    state_d    = S_MULT;
                    addr_sel_d = 1'b1;
                    hash_d     = '0;
                end
            end

            S_LOAD: begin
                if (!bus.m_empty) begin
                    m_re      = 1'b1;
                    en_column = COLS'(1) << col_q;
                    if (row_q == ROW_LAST) begin
                        row_d = '0;
                        if (col_q == COL_LAST) begin
                            col_d   = '0;
                            valid_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end

            S_MULT: begin
                if (!bus.hashin_empty) begin
                    hashin_re = 1'b1;
                    pe_en     = 1'b1;
                    en_column = '1;
                    if (hash_q == HASH_LAST) begin
                        hash_d  = '0;
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        hash_d = hash_q + HW'(1);
                    end
                end
            end

            S_DRAIN: begin
                // Keep the PE pipeline clocked until the last product has reached the result.
                pe_en = 1'b1;
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    out_d   = '0;
                    state_d = S_OUT;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end

            S_OUT: begin
                if (!bus.fifo_full) begin
                    hashout_we = 1'b1;
                    if (out_q == OUT_LAST) begin
                        out_d   = '0;
                        jobs_d  = jobs_q + 32'd1;
                        state_d = S_IDLE;
                    end else begin
                        out_d = out_q + OW'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.m_re         = m_re;
    assign bus.m_ram_we     = m_re;
    assign bus.m_row        = row_q;
    assign bus.en_column    = en_column;
    assign bus.addr_sel     = addr_sel_q;
    assign bus.hash_idx     = hash_q;
    assign bus.hashin_re    = hashin_re;
    assign bus.PE_en        = pe_en;
    assign bus.PE_clr       = pe_clr;
    assign bus.out_idx      = out_q;
    assign bus.hashout_we   = hashout_we;
    assign bus.matrix_valid = valid_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.job_count    = jobs_q;
    assign bus.state_dbg    = state_q;

    a_m_re_safe : assert property (@(posedge clk) disable iff (!rst_n) !(m_re && bus.m_empty));
    a_hin_safe  : assert property (@(posedge clk) disable iff (!rst_n) !(hashin_re && bus.hashin_empty));
    a_out_safe  : assert property (@(posedge clk) disable iff (!rst_n) !(hashout_we && bus.fifo_full));
endmodule

// File: tb/tb_matrix_ctrl_gen.sv
// Directed bench for matrix_ctrl_gen on a 4x4 matrix, 4-word hash, 2-word result, 3-cycle PE latency.
module tb_matrix_ctrl_gen;
    localparam int COLS       = 4;
    localparam int ROWS       = 4;
    localparam int HASH_WORDS = 4;
    localparam int OUT_WORDS  = 2;
    localparam int PE_LAT     = 3;
    localparam int RW         = 2;
    localparam int EW         = COLS + RW;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    logic [EW-1:0] exp_q[$];
    logic [31:0]   out_exp_q[$];

    matrix_ctrl_gen_if #(
        .COLS(COLS), .ROWS(ROWS), .HASH_WORDS(HASH_WORDS), .OUT_WORDS(OUT_WORDS)
    ) bus ();

    matrix_ctrl_gen #(
        .COLS(COLS), .ROWS(ROWS), .HASH_WORDS(HASH_WORDS),
        .OUT_WORDS(OUT_WORDS), .PE_LAT(PE_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mre"},  32'(bus.m_re), 32'd0);
        check({tag, "_mwe"},  32'(bus.m_ram_we), 32'd0);
        check({tag, "_row"},  32'(bus.m_row), 32'd0);
        check({tag, "_en"},   32'(bus.en_column), 32'd0);
        check({tag, "_asel"}, 32'(bus.addr_sel), 32'd0);
        check({tag, "_hidx"}, 32'(bus.hash_idx), 32'd0);
        check({tag, "_hre"},  32'(bus.hashin_re), 32'd0);
        check({tag, "_pen"},  32'(bus.PE_en), 32'd0);
        check({tag, "_pclr"}, 32'(bus.PE_clr), 32'd0);
        check({tag, "_oidx"}, 32'(bus.out_idx), 32'd0);
        check({tag, "_we"},   32'(bus.hashout_we), 32'd0);
        check({tag, "_mv"},   32'(bus.matrix_valid), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_jobs"}, bus.job_count, 32'd0);
        check({tag, "_st"},   32'(bus.state_dbg), 32'd0);
    endtask

    // Starts in IDLE at a negedge; loads words until done or until abort_at words were taken.
    task automatic load_matrix(input int gap_at, input int abort_at);
        int words;
        int gap;
        int cycles;
        logic [COLS-1:0] oh;
        logic [EW-1:0]   e;
        words  = 0;
        gap    = 0;
        cycles = 0;
        exp_q.delete();
        for (int c = 0; c < COLS; c++) begin
            oh    = '0;
            oh[c] = 1'b1;
            for (int r = 0; r < ROWS; r++) exp_q.push_back({oh, RW'(r)});
        end
        bus.m_empty = 1'b0;
        #1;
        check("load_idle_mre", 32'(bus.m_re), 32'd0);
        check("load_idle_pclr", 32'(bus.PE_clr), 32'd0);
        @(negedge clk);
        while (words < COLS * ROWS && words != abort_at && cycles < 60) begin
            bus.m_empty = (words == gap_at && gap < 2);
            #1;
            if (bus.m_empty) begin
                gap++;
                check("gap_mre", 32'(bus.m_re), 32'd0);
                check("gap_en", 32'(bus.en_column), 32'd0);
                check("gap_row", 32'(bus.m_row), 32'(gap_at % ROWS));
            end else begin
                e = exp_q.pop_front();
                check("load_mre", 32'(bus.m_re), 32'd1);
                check("load_mwe", 32'(bus.m_ram_we), 32'd1);
                check("load_en", 32'(bus.en_column), 32'(e[EW-1:RW]));
                check("load_row", 32'(bus.m_row), 32'(e[RW-1:0]));
                check("load_mv", 32'(bus.matrix_valid), 32'd0);
                check("load_asel", 32'(bus.addr_sel), 32'd0);
                words++;
            end
            @(negedge clk);
            cycles++;
        end
        check("load_words", 32'(words), (abort_at < 0) ? 32'(COLS * ROWS) : 32'(abort_at));
        if (abort_at < 0) begin
            bus.m_empty      = 1'b1;
            bus.hashin_empty = 1'b1;
            #1;
            check("load_done_mv", 32'(bus.matrix_valid), 32'd1);
            check("load_done_busy", 32'(bus.busy), 32'd0);
        end
    endtask

    // Runs one job starting at the IDLE cycle; fifo_full held for 'stall' cycles at the start of OUT.
    task automatic run_job(input int stall, input int reload_at, input int exp_jobs);
        int hre;
        int pen;
        int clr;
        int we;
        int we_full;
        int total;
        hre = 0; pen = 0; clr = 0; we = 0; we_full = 0;
        total = 1 + HASH_WORDS + PE_LAT + OUT_WORDS + stall;
        exp_q.delete();
        out_exp_q.delete();
        for (int i = 0; i < HASH_WORDS; i++) exp_q.push_back(EW'(i));
        for (int i = 0; i < OUT_WORDS; i++) out_exp_q.push_back(32'(i));
        for (int c = 0; c < total; c++) begin
            bus.hashin_empty  = (hre >= HASH_WORDS);
            bus.fifo_full     = (c >= total - OUT_WORDS - stall) && (c < total - OUT_WORDS);
            bus.matrix_reload = (c == reload_at);
            #1;
            if (bus.PE_clr) clr++;
            if (bus.PE_en) pen++;
            if (bus.hashin_re) begin
                hre++;
                if (exp_q.size() > 0) check("mult_idx", 32'(bus.hash_idx), 32'(exp_q.pop_front()));
                else check("mult_extra", 32'd1, 32'd0);
                check("mult_en", 32'(bus.en_column), 32'({COLS{1'b1}}));
                check("mult_asel", 32'(bus.addr_sel), 32'd1);
            end
            if (bus.hashout_we) begin
                we++;
                if (out_exp_q.size() > 0) check("out_idx", 32'(bus.out_idx), out_exp_q.pop_front());
                else check("out_extra", 32'd1, 32'd0);
            end
            if (bus.fifo_full) begin
                if (bus.hashout_we) we_full++;
                check("full_idx", 32'(bus.out_idx), 32'd0);
            end
            @(negedge clk);
        end
        bus.matrix_reload = 1'b0;
        bus.hashin_empty  = 1'b1;
        bus.fifo_full     = 1'b0;
        #1;
        check("job_pclr", 32'(clr), 32'd1);
        check("job_hre", 32'(hre), 32'(HASH_WORDS));
        check("job_pen", 32'(pen), 32'(HASH_WORDS + PE_LAT));
        check("job_we", 32'(we), 32'(OUT_WORDS));
        check("job_we_full", 32'(we_full), 32'd0);
        check("job_count", bus.job_count, 32'(exp_jobs));
        check("job_busy", 32'(bus.busy), 32'd0);
        check("job_state", 32'(bus.state_dbg), 32'd0);
        check("job_mv", 32'(bus.matrix_valid), 32'd1);
    endtask

    initial begin
        tests             = 0;
        failed            = 0;
        rst_n             = 1'b0;
        bus.m_empty       = 1'b1;
        bus.hashin_empty  = 1'b1;
        bus.fifo_full     = 1'b0;
        bus.matrix_reload = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // first load with a two-cycle M fifo gap at word 6
        load_matrix(6, -1);

        // clean job, then a job with five cycles of hashout back-pressure
        run_job(0, -1, 1);
        run_job(5, -1, 2);

        // reload pulsed during MULT with both fifos non-empty
        bus.m_empty = 1'b0;
        run_job(0, 2, 3);
        bus.hashin_empty = 1'b0;
        load_matrix(-1, -1);

        // reload request, then reset in the middle of the load
        bus.matrix_reload = 1'b1;
        @(negedge clk);
        bus.matrix_reload = 1'b0;
        load_matrix(-1, 9);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        rst_n            = 1'b1;
        bus.m_empty      = 1'b1;
        bus.hashin_empty = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check("post_rst_busy", 32'(bus.busy), 32'd0);
            check("post_rst_hre", 32'(bus.hashin_re), 32'd0);
            check("post_rst_pclr", 32'(bus.PE_clr), 32'd0);
            check("post_rst_mv", 32'(bus.matrix_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
